// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter with a one-entry holding register.
// Frames are a start bit, LSB-first data, optional parity and stop bit(s).
// Ports: clk, reset (sync, active-high), data_in/valid_in/ready handshake,
// tx_out serial line (idle high), busy (frame in progress), done (last stop clk).
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_param
    $error("uart_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         baud;
  logic [CW-1:0]         baud_n;
  logic [BW-1:0]         bits;
  logic [BW-1:0]         bits_n;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_n;
  logic                  par;
  logic                  par_n;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] hold_n;
  logic                  hold_full;
  logic                  hold_full_n;
  logic                  tx_n;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  accept;
  logic                  baud_end;
  logic                  stop_end;

  assign ready    = ~hold_full & ~reset;
  assign accept   = valid_in & ready;
  assign busy     = (state != IDLE);
  assign baud_end = (baud == BAUD_LAST);
  assign stop_end = (state == STOP) & baud_end &
                    (bits == STOP_LAST);
  // Reset wins over a coincident final stop cycle.
  assign done     = stop_end & ~reset;

  always_comb begin
    state_n     = state;
    baud_n      = baud_end ? '0 : baud + CW'(1);
    bits_n      = bits;
    shreg_n     = shreg;
    par_n       = par;
    hold_n      = hold;
    hold_full_n = hold_full;
    tx_n        = tx_out;
    load        = 1'b0;
    load_val    = data_in;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (accept) load = 1'b1;
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          bits_n  = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bits == DATA_LAST) begin
            bits_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = par;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bits_n  = bits + BW'(1);
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
      PARITY: begin
        if (baud_end) begin
          state_n = STOP;
          bits_n  = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (bits == STOP_LAST) begin
            // Chain straight into the next start bit when a
            // byte is waiting, so frames abut with no gap.
            if (hold_full) begin
              load        = 1'b1;
              load_val    = hold;
              hold_full_n = 1'b0;
            end else if (accept) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bits_n = bits + BW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
    if (load) begin
      state_n = START;
      baud_n  = '0;
      bits_n  = '0;
      shreg_n = load_val;
      par_n   = (^load_val) ^ (PARITY_ODD != 0);
      tx_n    = 1'b0;
    end else if (accept) begin
      hold_n      = data_in;
      hold_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= '0;
      bits      <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_out    <= 1'b1;
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bits      <= bits_n;
      shreg     <= shreg_n;
      par       <= par_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      tx_out    <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx instances (8N1, 8E1, 8O1, 8N2) at 4 clks/bit
// checked cycle by cycle against a per-instance line-level model.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int ND  = 4;
  localparam int QD  = 128;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valid;
  logic [7:0] data [ND];
  logic [3:0] ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(CPB), .DATA_WIDTH(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_n1 (
    .clk(clk), .reset(reset), .data_in(data[0]),
    .valid_in(valid[0]), .ready(ready[0]), .tx_out(tx[0]),
    .busy(busy[0]), .done(done[0])
  );

  uart_tx #(
    .CLKS_PER_BIT(CPB), .DATA_WIDTH(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_e1 (
    .clk(clk), .reset(reset), .data_in(data[1]),
    .valid_in(valid[1]), .ready(ready[1]), .tx_out(tx[1]),
    .busy(busy[1]), .done(done[1])
  );

  uart_tx #(
    .CLKS_PER_BIT(CPB), .DATA_WIDTH(8),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) u_o1 (
    .clk(clk), .reset(reset), .data_in(data[2]),
    .valid_in(valid[2]), .ready(ready[2]), .tx_out(tx[2]),
    .busy(busy[2]), .done(done[2])
  );

  uart_tx #(
    .CLKS_PER_BIT(CPB), .DATA_WIDTH(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) u_n2 (
    .clk(clk), .reset(reset), .data_in(data[3]),
    .valid_in(valid[3]), .ready(ready[3]), .tx_out(tx[3]),
    .busy(busy[3]), .done(done[3])
  );

  // Model: per instance, a queue of future line samples {level, last}.
  logic [1:0] line [ND][QD];
  int         head [ND];
  int         cnt  [ND];
  int         nfr  [ND];
  logic [3:0] got  [ND];
  logic [3:0] want [ND];
  logic [3:0] acc;
  int         nvec  = 0;
  int         nfail = 0;

  function automatic int pen(int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int podd(int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int nstop(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic push_frame(int i, logic [7:0] b);
    logic [11:0] fb;
    int          nb;
    int          slot;
    fb = '0;
    nb = 1;
    for (int k = 0; k < 8; k++) begin
      fb[nb] = b[k];
      nb++;
    end
    if (pen(i) == 1) begin
      fb[nb] = 1'(($countones(b) + podd(i)) % 2);
      nb++;
    end
    for (int k = 0; k < nstop(i); k++) begin
      fb[nb] = 1'b1;
      nb++;
    end
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        slot = (head[i] + cnt[i]) % QD;
        line[i][slot] = {fb[k], (k == nb - 1 && c == CPB - 1)};
        cnt[i]++;
      end
    end
    nfr[i]++;
  endtask

  // Sample this cycle, predict it, then advance model across the edge.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      got[i] = {tx[i], busy[i], done[i], ready[i]};
      if (cnt[i] > 0)
        want[i] = {line[i][head[i]][1], 1'b1,
                   line[i][head[i]][0] & ~reset, 1'b0};
      else
        want[i] = 4'b1000;
      want[i][0] = ~reset && nfr[i] < 2;
      acc[i] = valid[i] && want[i][0];
    end
    @(posedge clk);
    for (int i = 0; i < ND; i++) begin
      if (reset) begin
        head[i] = 0;
        cnt[i]  = 0;
        nfr[i]  = 0;
      end else begin
        if (cnt[i] > 0) begin
          if (line[i][head[i]][0]) nfr[i]--;
          head[i] = (head[i] + 1) % QD;
          cnt[i]--;
        end
        if (acc[i]) push_frame(i, data[i]);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = '1;
    for (int i = 0; i < ND; i++) data[i] = 8'($urandom);
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        reset = 1'b0;
        valid = '0;
      end
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL reset dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, c, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] wave;
    logic [2:0] w3;
    wave = 10'b11_0100_1010;
    valid = 4'b0001;
    data[0] = 8'hA5;
    for (int c = 0; c <= 41; c++) begin
      if (c == 1) valid = '0;
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL single dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, c, got[i], want[i]);
        end
      end
      if (c >= 1) begin
        if (c <= 40) w3 = {wave[(c - 1) / 4], 1'b1, (c == 40)};
        else w3 = 3'b100;
        nvec++;
        if (got[0][3:1] !== w3) begin
          nfail++;
          $display("FAIL a5_wave c%0d {tx,busy,done} got %b want %b",
                   c, got[0][3:1], w3);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    int idx   [ND];
    int ndone [ND];
    int t_ff  [ND];
    int ff_at [ND];
    int cyc;
    bit fin;
    seq   = '{8'h55, 8'h0F, 8'hFF};
    ff_at = '{41, 45, 45, 45};
    for (int i = 0; i < ND; i++) begin
      idx[i]   = 0;
      ndone[i] = 0;
      t_ff[i]  = -1;
    end
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 400) begin
      for (int i = 0; i < ND; i++) begin
        valid[i] = (idx[i] < 3);
        data[i]  = seq[(idx[i] < 3) ? idx[i] : 0];
      end
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL b2b dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, cyc, got[i], want[i]);
        end
        if (got[i][1]) ndone[i]++;
        if (idx[i] == 2 && got[i][0] && t_ff[i] < 0) t_ff[i] = cyc;
        if (acc[i]) idx[i]++;
      end
      if (cyc == 41) begin
        nvec++;
        if (got[0][3:2] !== 2'b01) begin
          nfail++;
          $display("FAIL b2b_gap {tx,busy} got %b want 01", got[0][3:2]);
        end
      end
      cyc++;
      fin = 1'b1;
      for (int i = 0; i < ND; i++)
        if (idx[i] < 3 || cnt[i] > 0) fin = 1'b0;
    end
    valid = '0;
    nvec++;
    if (!fin) begin
      nfail++;
      $display("FAIL b2b_timeout cycles %0d limit 400", cyc);
    end
    for (int i = 0; i < ND; i++) begin
      nvec++;
      if (t_ff[i] != ff_at[i] || ndone[i] != 3) begin
        nfail++;
        $display("FAIL b2b_ff dut%0d ready_at %0d want %0d, done %0d want 3",
                 i, t_ff[i], ff_at[i], ndone[i]);
      end
    end
  endtask

  task automatic test_parity();
    logic [3:0] at37;
    int first [ND];
    int len   [ND];
    len = '{40, 44, 44, 44};
    at37 = '0;
    for (int i = 0; i < ND; i++) begin
      first[i] = -1;
      data[i]  = 8'h07;
    end
    for (int c = 0; c <= 46; c++) begin
      valid = (c == 0) ? '1 : '0;
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL parity dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, c, got[i], want[i]);
        end
        if (c == 37) at37[i] = got[i][3];
        if (got[i][1] && first[i] < 0) first[i] = c;
      end
    end
    nvec++;
    if (at37 !== 4'b1011) begin
      nfail++;
      $display("FAIL parity_bit got %b want 1011", at37);
    end
    for (int i = 0; i < ND; i++) begin
      nvec++;
      if (first[i] != len[i]) begin
        nfail++;
        $display("FAIL frame_len dut%0d got %0d want %0d",
                 i, first[i], len[i]);
      end
    end
  endtask

  task automatic test_stop2();
    logic [2:0] w3;
    data[3] = 8'h00;
    for (int c = 0; c <= 46; c++) begin
      valid = (c == 0) ? 4'b1000 : 4'b0000;
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL stop2 dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, c, got[i], want[i]);
        end
      end
      if (c >= 1) begin
        w3 = {(c >= 37), (c <= 44), (c == 44)};
        nvec++;
        if (got[3][3:1] !== w3) begin
          nfail++;
          $display("FAIL stop2_wave c%0d {tx,busy,done} got %b want %b",
                   c, got[3][3:1], w3);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone [ND];
    for (int i = 0; i < ND; i++) ndone[i] = 0;
    for (int c = 0; c < 80; c++) begin
      valid = (c < 2) ? '1 : '0;
      for (int i = 0; i < ND; i++) data[i] = (c == 0) ? 8'h81 : 8'h42;
      reset = (c == 18);
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL rst_mid dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, c, got[i], want[i]);
        end
        if (c >= 18 && got[i][1]) ndone[i]++;
        if (c == 19) begin
          nvec++;
          if (got[i][3:2] !== 2'b10) begin
            nfail++;
            $display("FAIL rst_mid_line dut%0d {tx,busy} got %b want 10",
                     i, got[i][3:2]);
          end
        end
      end
    end
    reset = 1'b0;
    for (int i = 0; i < ND; i++) begin
      nvec++;
      if (ndone[i] != 0) begin
        nfail++;
        $display("FAIL rst_mid_done dut%0d got %0d want 0", i, ndone[i]);
      end
      ndone[i] = 0;
      data[i]  = 8'h3C;
    end
    for (int c = 0; c < 55; c++) begin
      valid = (c == 0) ? '1 : '0;
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL rst_after dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, c, got[i], want[i]);
        end
        if (got[i][1]) ndone[i]++;
      end
    end
    for (int i = 0; i < ND; i++) begin
      nvec++;
      if (ndone[i] != 1) begin
        nfail++;
        $display("FAIL rst_after_done dut%0d got %0d want 1", i, ndone[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < ND; i++) begin
        valid[i] = ($urandom_range(0, 2) == 0);
        data[i]  = 8'($urandom);
      end
      tick();
      for (int i = 0; i < ND; i++) begin
        nvec++;
        if (got[i] !== want[i]) begin
          nfail++;
          if (nfail <= 40)
            $display("FAIL random dut%0d c%0d {tx,busy,done,ready} got %b want %b",
                     i, c, got[i], want[i]);
        end
      end
    end
    reset = 1'b0;
    valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    valid = '0;
    for (int i = 0; i < ND; i++) begin
      data[i] = '0;
      head[i] = 0;
      cnt[i]  = 0;
      nfr[i]  = 0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter. It accepts parallel bytes over a valid/ready handshake and serialises each one onto tx_out as an asynchronous frame: start bit, data bits LSB-first, optional parity bit, then stop bit(s). A one-entry holding register lets the next byte be accepted while the current frame is on the wire, so back-to-back frames go out with no idle gap. It is the transmit-side counterpart of the UART receive path and uses the same frame format.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 2
DATA_WIDTH, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
data_in  input  DATA_WIDTH  byte to transmit
valid_in  input  1  data_in is valid
ready  output  1  holding register empty; a byte is accepted on any edge where valid_in & ready
tx_out  output  1  serial line; idle high; driven straight from a flop
busy  output  1  a frame is in progress (state != IDLE)
done  output  1  one-cycle pulse in the last clk of the final stop bit

Behaviour:
- Reset values (clk clk, reset reset, synchronous, active-high): tx_out=1, ready=1, busy=0, done=0, state=IDLE, holding register empty, bit counter=0, baud counter=0.
- ready is 0 on any cycle in which reset is high.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after DATA_WIDTH bits, if PARITY_EN=1.
  - DATA -> STOP after DATA_WIDTH bits, if PARITY_EN=0.
  - PARITY -> STOP after 1 bit.
  - STOP -> START if the holding register is full, or valid_in & ready on that edge; otherwise STOP -> IDLE. This transition happens after STOP_BITS*CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets to 0 on every state entry. Each bit occupies exactly CLKS_PER_BIT cycles. No free-running baud tick, so there is no start-phase jitter.
- Latency: on an accept edge while IDLE, the byte loads directly into the shift register. tx_out=0 and busy=1 from that edge onward, i.e. the start bit begins on the cycle after accept.
- Data is shifted LSB first. tx_out holds each data bit for CLKS_PER_BIT cycles.
- Parity bit = XOR of the DATA_WIDTH data bits, inverted when PARITY_ODD=1. It is computed from the latched byte, not from data_in.
- Frame length is exactly (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Accept while busy: the byte goes into the holding register and ready drops on the next edge.
- A second valid_in while the holding register is full is ignored: no accept, and data_in is not sampled.
- End of final stop bit:
  - done=1 for that single cycle.
  - If the holding register is full: its contents load into the shift register, the next start bit begins on the following cycle (zero idle gap), and ready rises on the same edge.
  - If the holding register is empty and valid_in is high: that byte loads directly and the next start bit also begins with zero gap.
  - Otherwise: IDLE, tx_out=1, busy=0.
- data_in may change freely after the accept edge. The transmitted byte equals the value sampled at accept.
- Reset mid-frame: on the reset edge tx_out returns to 1, the holding register is cleared, and done does not pulse. No partial frame resumes.
- Illegal parameter values (CLKS_PER_BIT < 2, STOP_BITS not 1 or 2) are caught by an elaboration-time assertion.

Test Plan:
- Reset: hold reset 3 cycles -> tx_out=1, ready=1 after release, busy=0, done=0; with reset high, ready=0.
- Single byte, CLKS_PER_BIT=4, 8N1: send 0xA5 -> tx_out, 4 cycles per bit, is 0,1,0,1,0,0,1,0,1,1; start bit on the cycle after accept; done pulses at cycle 40 of the frame; busy falls the cycle after.
- Back-to-back: send 0x55, then 0x0F while busy, then valid_in with 0xFF while the holding register is full -> 0xFF not accepted and ready=0 until the 0x55 frame ends; the 0x0F start bit immediately follows the 0x55 stop bit with zero gap; 0xFF is accepted afterwards and sent third.
- Parity, CLKS_PER_BIT=4, 8E1 then 8O1: send 0x07 -> parity bit 1 for even, 0 for odd; frame length 44 cycles.
- 2 stop bits: send 0x00 -> stop period high for 8 cycles; done pulses only in the last stop cycle.
- Reset mid-frame: assert reset during data bit 3 with a byte in the holding register -> tx_out=1 the next cycle, no done pulse, holding byte discarded, and the next accepted byte 0x3C transmits correctly.
